// File: rtl/soc_host_sequencer_if.sv
// Command/response handshake bundle between host logic and soc_host_sequencer.
// The master drives commands and consumes responses; the slave is the sequencer.
interface soc_host_sequencer_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_status;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_status, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_status, rsp_data
  );
endinterface

// File: rtl/soc_host_sequencer.sv
// Serializes write, read and kernel-execution traffic onto the soc_pad host
// interface, one command at a time, with timeout-protected waits.
module soc_host_sequencer #(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 16,
  parameter int RD_TIMEOUT   = 256,
  parameter int EXEC_TIMEOUT = 65535,
  parameter int ARM_CYCLES   = 4
) (
  input  logic              clk,
  input  logic              rstn,
  soc_host_sequencer_if.slave host,
  output logic              chip_en,
  output logic              data_addr_valid,
  output logic              read_write,
  output logic [ADDR_W-1:0] address_in,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  input  logic              data_out_valid,
  output logic              scan_start_exec,
  output logic              trigger,
  input  logic              exec_end
);

  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, ARM, TRIG, RUN, RSP} state_t;
  typedef enum logic [1:0] {OP_WRITE = 2'b00, OP_READ = 2'b01, OP_EXEC = 2'b10, OP_RSVD = 2'b11} op_t;
  typedef enum logic [1:0] {ST_OK = 2'b00, ST_TIMEOUT = 2'b01, ST_BAD_OP = 2'b10} status_t;

  // One counter serves the ARM, RD_WAIT and RUN phases, sized for the largest limit.
  localparam int MAX_RE  = (RD_TIMEOUT > EXEC_TIMEOUT) ? RD_TIMEOUT : EXEC_TIMEOUT;
  localparam int CNT_MAX = (MAX_RE > ARM_CYCLES) ? MAX_RE : ARM_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RD_LIMIT   = CNT_W'(RD_TIMEOUT);
  localparam logic [CNT_W-1:0] EXEC_LIMIT = CNT_W'(EXEC_TIMEOUT);
  localparam logic [CNT_W-1:0] ARM_LIMIT  = CNT_W'(ARM_CYCLES);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // NOTE: every register here is state updated on the clock edge, so all
  // assignments are non-blocking; the reset branch clears every register,
  // since reset must leave all outputs and counters at zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= IDLE;
      cnt             <= '0;
      host.cmd_ready  <= 1'b0;
      host.rsp_valid  <= 1'b0;
      host.rsp_status <= ST_OK;
      host.rsp_data   <= '0;
      chip_en         <= 1'b0;
      data_addr_valid <= 1'b0;
      read_write      <= 1'b0;
      address_in      <= '0;
      data_in         <= '0;
      scan_start_exec <= 1'b0;
      trigger         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          host.cmd_ready <= 1'b1;
          if (host.cmd_valid && host.cmd_ready) begin
            host.cmd_ready <= 1'b0;
            case (op_t'(host.cmd_op))
              OP_WRITE: begin
                state           <= WR;
                chip_en         <= 1'b1;
                data_addr_valid <= 1'b1;
                read_write      <= 1'b1;
                address_in      <= host.cmd_addr;
                data_in         <= host.cmd_data;
              end
              OP_READ: begin
                state           <= RD_REQ;
                chip_en         <= 1'b1;
                data_addr_valid <= 1'b1;
                read_write      <= 1'b0;
                address_in      <= host.cmd_addr;
              end
              OP_EXEC: begin
                state           <= ARM;
                chip_en         <= 1'b1;
                scan_start_exec <= 1'b1;
                cnt             <= CNT_W'(1);
              end
              default: begin
                state           <= RSP;
                host.rsp_valid  <= 1'b1;
                host.rsp_status <= ST_BAD_OP;
                host.rsp_data   <= '0;
              end
            endcase
          end
        end

        WR: begin
          state           <= RSP;
          chip_en         <= 1'b0;
          data_addr_valid <= 1'b0;
          read_write      <= 1'b0;
          address_in      <= '0;
          data_in         <= '0;
          host.rsp_valid  <= 1'b1;
          host.rsp_status <= ST_OK;
          host.rsp_data   <= '0;
        end

        RD_REQ: begin
          state           <= RD_WAIT;
          data_addr_valid <= 1'b0;
          address_in      <= '0;
          cnt             <= CNT_W'(1);
        end

        // cnt counts RD_WAIT cycles already sampled, starting at 1.
        RD_WAIT: begin
          if (data_out_valid) begin
            state           <= RSP;
            chip_en         <= 1'b0;
            host.rsp_valid  <= 1'b1;
            host.rsp_status <= ST_OK;
            host.rsp_data   <= data_out;
          end else if (cnt >= RD_LIMIT) begin
            state           <= RSP;
            chip_en         <= 1'b0;
            host.rsp_valid  <= 1'b1;
            host.rsp_status <= ST_TIMEOUT;
            host.rsp_data   <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end

        ARM: begin
          if (cnt >= ARM_LIMIT) begin
            state   <= TRIG;
            trigger <= 1'b1;
            cnt     <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end

        TRIG: begin
          state   <= RUN;
          trigger <= 1'b0;
          cnt     <= CNT_W'(1);
        end

        // exec_end is checked before the limit so a finish on the last
        // allowed cycle still reports OK.
        RUN: begin
          if (exec_end) begin
            state           <= RSP;
            chip_en         <= 1'b0;
            scan_start_exec <= 1'b0;
            host.rsp_valid  <= 1'b1;
            host.rsp_status <= ST_OK;
            host.rsp_data   <= DATA_W'(cnt);
          end else if (cnt >= EXEC_LIMIT) begin
            state           <= RSP;
            chip_en         <= 1'b0;
            scan_start_exec <= 1'b0;
            host.rsp_valid  <= 1'b1;
            host.rsp_status <= ST_TIMEOUT;
            host.rsp_data   <= DATA_W'(EXEC_LIMIT);
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end

        RSP: begin
          if (host.rsp_ready) begin
            state           <= IDLE;
            cnt             <= '0;
            host.rsp_valid  <= 1'b0;
            host.rsp_status <= ST_OK;
            host.rsp_data   <= '0;
            host.cmd_ready  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/soc_host_sequencer.md
Name: soc_host_sequencer

Overview:
Host-side controller that sequences all traffic on the soc_pad host interface: configuration/data writes, memory reads, and kernel execution (scan_start_exec/trigger/exec_end). It accepts one command at a time on a valid/ready command port and returns exactly one response per command on a valid/ready response port. The block sits between the test/host logic and soc_pad, and replaces hand-driven pad stimulus with a single serialized, timeout-protected sequencer.

Parameters:
DATA_W, 64, width of data_in, data_out, cmd_data and rsp_data
ADDR_W, 16, width of address_in and cmd_addr
RD_TIMEOUT, 256, maximum cycles to wait for data_out_valid after a read request
EXEC_TIMEOUT, 65535, maximum cycles to wait for exec_end after trigger
ARM_CYCLES, 4, cycles scan_start_exec is held before the trigger pulse; legal range 1..255

Ports:
clk  in  1  system clock
rstn  in  1  reset, synchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  2  00 WRITE, 01 READ, 10 EXEC, 11 reserved
cmd_addr  in  ADDR_W  target address (WRITE/READ)
cmd_data  in  DATA_W  write data (WRITE)
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_status  out  2  00 OK, 01 TIMEOUT, 10 BAD_OP
rsp_data  out  DATA_W  read data (READ), execution cycle count (EXEC), otherwise 0
chip_en  out  1  pad chip enable
data_addr_valid  out  1  address/data strobe to pad
read_write  out  1  1 = write, 0 = read
address_in  out  ADDR_W  pad address
data_in  out  DATA_W  pad write data
data_out  in  DATA_W  pad read data
data_out_valid  in  1  pad read data valid
scan_start_exec  out  1  execution arm
trigger  out  1  execution start pulse
exec_end  in  1  execution complete (level)

Behaviour:
- Reset (rstn=0 at a clk edge): state IDLE; all outputs 0, including cmd_ready, rsp_valid, rsp_status, rsp_data, all pad outputs, and internal counters. Reset mid-operation aborts the transaction immediately, and no response is issued.
- States: IDLE, WR, RD_REQ, RD_WAIT, ARM, TRIG, RUN, RSP.
- IDLE: cmd_ready=1. Accept in cycle T; cmd_addr and cmd_data are registered. The next state is WR, RD_REQ or ARM by op. Op 11 goes directly to RSP with BAD_OP and rsp_data 0, and no pad activity occurs.
- chip_en=1 in every state except IDLE and RSP.
- WR (cycle T+1, one cycle): data_addr_valid=1, read_write=1, address_in and data_in driven. Then RSP with OK and rsp_data 0.
- RD_REQ (one cycle): data_addr_valid=1, read_write=0, address_in driven; data_in=0. Then RD_WAIT.
- RD_WAIT: data_out_valid is sampled starting the cycle after RD_REQ; data_out_valid seen during RD_REQ is ignored. On the first data_out_valid=1, capture data_out and go to RSP with OK.
- RD_WAIT timeout: after RD_TIMEOUT cycles without data_out_valid, go to RSP with TIMEOUT and rsp_data 0.
- ARM: scan_start_exec=1 for exactly ARM_CYCLES cycles, then TRIG.
- TRIG (one cycle): scan_start_exec=1, trigger=1. Then RUN.
- RUN: scan_start_exec=1. A cycle counter starts at 1 in the first RUN cycle and increments each cycle. exec_end=1 sampled in RUN goes to RSP with OK and rsp_data = counter, zero-extended.
- RUN timeout: if the counter reaches EXEC_TIMEOUT with no exec_end, go to RSP with TIMEOUT and rsp_data = EXEC_TIMEOUT.
- exec_end is ignored outside RUN. If exec_end is already high in the first RUN cycle, the result is count 1.
- Pad outputs return to 0 on the cycle they leave their owning state. address_in and data_in are 0 whenever data_addr_valid=0.
- RSP: rsp_valid=1; rsp_status and rsp_data are held stable until rsp_ready. cmd_ready=0 throughout. On the handshake, go to IDLE; the next command can be accepted one cycle later.
- Counters saturate and never wrap.
- All outputs are registered, with no combinational input-to-output path.

Test Plan:
- WRITE addr 0x0010, data 0xDEAD_BEEF accepted at T -> at T+1 one cycle of data_addr_valid=1, read_write=1, address_in=0x0010, data_in=0xDEADBEEF; rsp OK, data 0, at T+2.
- READ addr 0x0020, bench returns data_out_valid with 0x1234 five cycles after RD_REQ -> rsp OK, rsp_data=0x1234; a data_out_valid pulse during RD_REQ is not captured.
- READ with no data_out_valid -> rsp TIMEOUT, data 0, exactly RD_TIMEOUT cycles after RD_REQ.
- EXEC, ARM_CYCLES=4, exec_end rises 10 cycles after trigger -> scan_start_exec high for 4+1+10 cycles, a single one-cycle trigger, rsp OK with rsp_data=10.
- cmd_op=11 -> BAD_OP response with no pad activity. Holding rsp_ready=0 for 20 cycles -> response stable and cmd_ready=0 throughout.
- rstn=0 asserted during RUN -> the next cycle has all outputs 0 and no response; after release, a WRITE completes normally.
